hgcal_input_quantizer_packer: RTL and testbench

//  Upstream feeder for the layer-0 LUT neurons. Accepts a stream of raw HGCAL cell samples, one per beat.

---
 rtl/hgcal_pkg.sv | 23 ++
 rtl/hgcal_quant2.sv | 22 ++
 rtl/hgcal_input_quantizer_packer.sv | 163 ++++++++++++++++
 tb/tb_hgcal_input_quantizer_packer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hgcal_pkg.sv
// Shared definitions for the HGCAL input quantizer/packer.
//   CODE_W, CODE_MAX : width and saturation value of a quantized code
//   packer_state_t   : packer sequencing states
//   quant2()         : code = min(sample >> shift, CODE_MAX)
package hgcal_pkg;

    localparam int unsigned    CODE_W   = 2;
    localparam logic [1:0]     CODE_MAX = 2'd3;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } packer_state_t;

    function automatic logic [CODE_W-1:0] quant2(input logic [31:0] sample,
                                                 input int unsigned shift);
        logic [31:0] s;
        s = sample >> shift;
        return (s > 32'd3) ? CODE_MAX : s[CODE_W-1:0];
    endfunction

endpackage

// File: rtl/hgcal_quant2.sv
// Combinational 2-bit quantizer for one raw sample.
// Ports:
//   sample : raw unsigned sample, DATA_W bits
//   code   : min(sample >> SHIFT, 3)
//   clip   : high when (sample >> SHIFT) exceeds the code range
module hgcal_quant2
    import hgcal_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned SHIFT  = 7
) (
    input  logic [DATA_W-1:0] sample,
    output logic [CODE_W-1:0] code,
    output logic              clip
);

    always_comb begin
        code = quant2(32'(sample), SHIFT);
        clip = ((32'(sample) >> SHIFT) > 32'd3);
    end

endmodule

// File: rtl/hgcal_input_quantizer_packer.sv
// Quantizes a stream of raw HGCAL samples to 2-bit codes and packs each frame of
// N_INPUTS codes into one wide vector for the layer-0 LUT neurons.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_data/in_valid    : raw sample stream, one sample per beat
//   in_last             : final sample of a frame
//   in_ready            : packer can accept (low only while a finished frame waits)
//   out_vec/out_valid   : packed frame, input i at bits [2i+1:2i]
//   out_ready           : downstream consumes the frame
//   frame_err           : one-cycle pulse when a frame is dropped on length mismatch
//   clip_cnt            : saturating count of clipped samples (only with QUANT_CLIP_CNT_EN)
// Optional feature macro: QUANT_CLIP_CNT_EN
module hgcal_input_quantizer_packer
    import hgcal_pkg::*;
#(
    parameter int unsigned N_INPUTS = 48,
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned SHIFT    = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [CODE_W*N_INPUTS-1:0] out_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       frame_err
`ifdef QUANT_CLIP_CNT_EN
    ,
    output logic [15:0]                clip_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(N_INPUTS);
    localparam int unsigned VEC_W = CODE_W * N_INPUTS;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

    packer_state_t      state, state_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [VEC_W-1:0]   acc, acc_next;
    logic [VEC_W-1:0]   out_vec_next;
    logic               out_valid_next;
    logic               frame_err_next;
    logic               in_ready_next;

    logic [CODE_W-1:0]  code;
    logic               clip;
    logic               accept;
    logic               consume;

    hgcal_quant2 #(
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT)
    ) u_quant (
        .sample (in_data),
        .code   (code),
        .clip   (clip)
    );

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_comb begin
        state_next     = state;
        count_next     = count;
        acc_next       = acc;
        out_vec_next   = out_vec;
        out_valid_next = out_valid;
        frame_err_next = 1'b0;

        // A refill below overrides this on the same edge (back-to-back frames).
        if (consume) begin
            out_valid_next = 1'b0;
        end

        case (state)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < int'(N_INPUTS); i++) begin
                        if (count == CNT_W'(i)) begin
                            acc_next[CODE_W*i +: CODE_W] = code;
                        end
                    end
                    if (count == LAST_IDX) begin
                        count_next = '0;
                        if (!in_last) begin
                            // Long frame: drop it and swallow beats through the next in_last.
                            frame_err_next = 1'b1;
                            state_next     = DISCARD;
                        end else if (!out_valid || out_ready) begin
                            out_vec_next   = acc_next;
                            out_valid_next = 1'b1;
                        end else begin
                            // OUT still held: park the finished frame in ACC.
                            state_next = FULL;
                        end
                    end else if (in_last) begin
                        count_next     = '0;
                        frame_err_next = 1'b1;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    out_vec_next   = acc;
                    out_valid_next = 1'b1;
                    state_next     = FILL;
                end
            end
            DISCARD: begin
                if (accept && in_last) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
                count_next = '0;
            end
        endcase

        // Registered from next state so in_ready has no path from in_valid.
        in_ready_next = (state_next != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            count     <= '0;
            acc       <= '0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            acc       <= acc_next;
            out_vec   <= out_vec_next;
            out_valid <= out_valid_next;
            frame_err <= frame_err_next;
            in_ready  <= in_ready_next;
        end
    end

`ifdef QUANT_CLIP_CNT_EN
    // Counts every clipped sample accepted outside DISCARD, even in frames later dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt <= '0;
        end else if (accept && (state == FILL) && clip && (clip_cnt != 16'hFFFF)) begin
            clip_cnt <= clip_cnt + 16'd1;
        end
    end
`else
    logic unused_clip;
    assign unused_clip = clip;
`endif

endmodule

// File: tb/tb_hgcal_input_quantizer_packer.sv
module tb_hgcal_input_quantizer_packer;

    localparam int unsigned N_INPUTS = 4;
    localparam int unsigned DATA_W   = 10;
    localparam int unsigned SHIFT    = 7;

    logic                  clk;
    logic                  rst_n;
    logic [DATA_W-1:0]     in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [2*N_INPUTS-1:0] out_vec;
    logic                  out_valid;
    logic                  out_ready;
    logic                  frame_err;
`ifdef QUANT_CLIP_CNT_EN
    logic [15:0]           clip_cnt;
`endif

    int total;
    int bad;

    hgcal_input_quantizer_packer #(
        .N_INPUTS (N_INPUTS),
        .DATA_W   (DATA_W),
        .SHIFT    (SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
`ifdef QUANT_CLIP_CNT_EN
        ,
        .clip_cnt  (clip_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted beat, then sample #1 after the edge.
    task automatic beat(input int data, input logic last);
        in_data  = DATA_W'(data);
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_vec;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_vec", 64'(out_vec), 64'd0);
`ifdef QUANT_CLIP_CNT_EN
        chk("rst_clip_cnt", 64'(clip_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // Test 1: basic frame, codes 0,1,2,3
        out_ready = 1'b1;
        beat(0, 1'b0);
        beat(128, 1'b0);
        beat(256, 1'b0);
        chk("t1_no_valid_early", 64'(out_valid), 64'd0);
        beat(1023, 1'b1);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_vec", 64'(out_vec), 64'hE4);
        idle();
        chk("t1_consumed", 64'(out_valid), 64'd0);
`ifdef QUANT_CLIP_CNT_EN
        chk("t1_clip_cnt", 64'(clip_cnt), 64'd1);
`endif

        // Test 2: backpressure, frame A held while B completes
        out_ready = 1'b0;
        beat(384, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(128, 1'b1);
        chk("t2_a_valid", 64'(out_valid), 64'd1);
        chk("t2_a_vec", 64'(out_vec), 64'h43);
        chk("t2_a_in_ready", 64'(in_ready), 64'd1);
        beat(128, 1'b0);
        beat(128, 1'b0);
        beat(256, 1'b0);
        beat(256, 1'b1);
        chk("t2_full_in_ready", 64'(in_ready), 64'd0);
        chk("t2_hold_vec", 64'(out_vec), 64'h43);
        idle();
        chk("t2_hold_vec2", 64'(out_vec), 64'h43);
        chk("t2_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        idle();
        chk("t2_b_vec", 64'(out_vec), 64'hA5);
        chk("t2_b_valid", 64'(out_valid), 64'd1);
        chk("t2_b_in_ready", 64'(in_ready), 64'd1);
        idle();
        chk("t2_b_consumed", 64'(out_valid), 64'd0);

        // Test 3: short frame then a good frame from bit 0
        beat(128, 1'b0);
        beat(128, 1'b1);
        chk("t3_frame_err", 64'(frame_err), 64'd1);
        chk("t3_no_valid", 64'(out_valid), 64'd0);
        idle();
        chk("t3_err_pulse", 64'(frame_err), 64'd0);
        beat(1023, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b1);
        chk("t3_good_valid", 64'(out_valid), 64'd1);
        chk("t3_good_vec", 64'(out_vec), 64'h03);
        idle();

        // Test 4: long frame of 6 beats
        beat(384, 1'b0);
        beat(384, 1'b0);
        beat(384, 1'b0);
        chk("t4_no_err_early", 64'(frame_err), 64'd0);
        beat(384, 1'b0);
        chk("t4_frame_err", 64'(frame_err), 64'd1);
        beat(384, 1'b0);
        chk("t4_err_once", 64'(frame_err), 64'd0);
        chk("t4_discard_ready", 64'(in_ready), 64'd1);
        beat(384, 1'b1);
        chk("t4_discard_err", 64'(frame_err), 64'd0);
        chk("t4_discard_valid", 64'(out_valid), 64'd0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(384, 1'b1);
        chk("t4_next_valid", 64'(out_valid), 64'd1);
        chk("t4_next_vec", 64'(out_vec), 64'hC0);
        idle();

        // Test 5: continuous frames, no bubbles
        for (int f = 0; f < 3; f++) begin
            exp_vec = '0;
            for (int k = 0; k < 4; k++) begin
                exp_vec[2*k +: 2] = 2'((f + k) % 4);
                beat(((f + k) % 4) * 128, (k == 3));
                chk("t5_in_ready", 64'(in_ready), 64'd1);
                chk("t5_out_valid", 64'(out_valid), (k == 3) ? 64'd1 : 64'd0);
            end
            chk("t5_out_vec", 64'(out_vec), 64'(exp_vec));
        end
        idle();

        // Test 6: reset mid-operation
        out_ready = 1'b0;
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b1);
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        beat(128, 1'b1);
        chk("t6_pre_err", 64'(frame_err), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_err", 64'(frame_err), 64'd0);
        chk("t6_rst_vec", 64'(out_vec), 64'd0);
`ifdef QUANT_CLIP_CNT_EN
        chk("t6_rst_clip", 64'(clip_cnt), 64'd0);
`endif
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle();
        chk("t6_rel_ready", 64'(in_ready), 64'd1);
        beat(256, 1'b0);
        beat(0, 1'b0);
        beat(1023, 1'b0);
        beat(128, 1'b1);
        chk("t6_fresh_valid", 64'(out_valid), 64'd1);
        chk("t6_fresh_vec", 64'(out_vec), 64'h72);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
